// File: rtl/pooling_pkg.sv
// pooling_pkg: shared constants, derived bus/lane widths and FSM state type for pooling_core.
package pooling_pkg;
  localparam int DEF_BOTTLENECK = 32;
  localparam int DEF_SIZE = 2;
  localparam int DEF_STRIDE = 2;
  localparam int DEF_DELTA_X = 4;
  localparam int DEF_OU = 4;
  localparam int DEF_IN_CH = 512;
  localparam int DEF_IFM_BIT = 8;
  localparam int NUM_CYCLE = DEF_BOTTLENECK / DEF_DELTA_X * DEF_OU * DEF_STRIDE;
  localparam int NUM_POOLING = DEF_IN_CH / NUM_CYCLE;
  localparam int WIN = DEF_SIZE * DEF_SIZE;
  localparam int LANE_W = WIN * DEF_IFM_BIT;
  localparam int ACT_W = NUM_POOLING * LANE_W;
  localparam int POOL_W = NUM_POOLING * DEF_IFM_BIT;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
endpackage

// File: rtl/pooling_if.sv
// pooling_if: activation-in / result-out bus; avg_mode exists only when POOLING_AVG_EN is defined.
interface pooling_if #(
  parameter int AW = pooling_pkg::ACT_W,
  parameter int PW = pooling_pkg::POOL_W
);
  logic in_valid;
  logic [AW-1:0] ACTIVATION;
  logic out_valid;
  logic [PW-1:0] Pooling;
`ifdef POOLING_AVG_EN
  logic avg_mode;
  modport master(output in_valid, ACTIVATION, avg_mode, input out_valid, Pooling);
  modport slave(input in_valid, ACTIVATION, avg_mode, output out_valid, Pooling);
`else
  modport master(output in_valid, ACTIVATION, input out_valid, Pooling);
  modport slave(input in_valid, ACTIVATION, output out_valid, Pooling);
`endif
endinterface

// File: rtl/pool_lane.sv
// pool_lane: one channel's window accumulator (max, or sum/average under POOLING_AVG_EN).
module pool_lane #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 4,
  parameter int SEL_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
`ifdef POOLING_AVG_EN
  input  logic                     avg_i,
`endif
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [N_ELEM*ELEM_W-1:0] win_i,
  output logic [ELEM_W-1:0]        res_o
);
`ifdef POOLING_AVG_EN
  localparam int AW = ELEM_W + $clog2(N_ELEM + 1);
`else
  localparam int AW = ELEM_W;
`endif
  logic [AW-1:0] acc_q, acc_d;
  logic [ELEM_W-1:0] elem;
  // res_o reflects acc_d so the core can latch the final value on the DONE entry edge
  always_comb begin
    elem = win_i[sel_i*ELEM_W +: ELEM_W];
`ifdef POOLING_AVG_EN
    acc_d = clr_i ? '0 : !en_i ? acc_q : avg_i ? acc_q + AW'(elem) : (AW'(elem) > acc_q ? AW'(elem) : acc_q);
    res_o = avg_i ? ELEM_W'(acc_d / AW'(N_ELEM)) : acc_d[ELEM_W-1:0];
`else
    acc_d = clr_i ? '0 : (en_i && elem > acc_q) ? elem : acc_q;
    res_o = acc_d;
`endif
  end
  always_ff @(posedge clk)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/pooling_core.sv
// pooling_core: WIN-element window pooling over NUM_POOLING channels; POOLING_AVG_EN adds average mode.
module pooling_core import pooling_pkg::*; #(
  parameter int BOTTLENECK = DEF_BOTTLENECK,
  parameter int SIZE = DEF_SIZE,
  parameter int STRIDE = DEF_STRIDE,
  parameter int DELTA_X = DEF_DELTA_X,
  parameter int OU = DEF_OU,
  parameter int IN_CH = DEF_IN_CH,
  parameter int IFM_BIT = DEF_IFM_BIT
) (
  input logic       clk,
  input logic       rst,
  pooling_if.slave  pool_bus
);
  localparam int NP = IN_CH / (BOTTLENECK / DELTA_X * OU * STRIDE);
  localparam int NW = SIZE * SIZE;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NP*NW*IFM_BIT-1:0] act_q, act_d;
  logic [NP*IFM_BIT-1:0] pool_q, pool_d, lane_res;
  logic accept, scan, last;
`ifdef POOLING_AVG_EN
  logic avg_q, avg_d;
`endif
  // new input is taken in IDLE and DONE only; during SCAN it is dropped
  always_comb begin
    accept = pool_bus.in_valid && state_q != SCAN;
    scan = state_q == SCAN;
    last = scan && cnt_q == CW'(NW - 1);
    state_d = accept ? SCAN : last ? DONE : scan ? SCAN : IDLE;
    cnt_d = accept ? '0 : scan ? cnt_q + 1'b1 : cnt_q;
    act_d = accept ? pool_bus.ACTIVATION : act_q;
    pool_d = last ? lane_res : pool_q;
`ifdef POOLING_AVG_EN
    avg_d = accept ? pool_bus.avg_mode : avg_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      act_q <= '0;
      pool_q <= '0;
`ifdef POOLING_AVG_EN
      avg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      pool_q <= pool_d;
`ifdef POOLING_AVG_EN
      avg_q <= avg_d;
`endif
    end
  end
  for (genvar c = 0; c < NP; c++) begin : g_lane
    pool_lane #(.ELEM_W(IFM_BIT), .N_ELEM(NW), .SEL_W(CW)) u_lane (
      .clk(clk),
      .rst(rst),
      .clr_i(accept),
      .en_i(scan),
`ifdef POOLING_AVG_EN
      .avg_i(avg_q),
`endif
      .sel_i(cnt_q),
      .win_i(act_q[c*NW*IFM_BIT +: NW*IFM_BIT]),
      .res_o(lane_res[c*IFM_BIT +: IFM_BIT])
    );
  end
  assign pool_bus.out_valid = state_q == DONE;
  assign pool_bus.Pooling = pool_q;
endmodule

// File: tb/tb_pooling_core.sv
// tb_pooling_core: directed + randomized checks of pooling_core against a window-level reference model.
module tb_pooling_core;
  import pooling_pkg::*;
  localparam int B = DEF_IFM_BIT;
  typedef struct {int at; logic [POOL_W-1:0] val;} want_t;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0, n_fail = 0, cyc = 0, last_acc = -1000;
  want_t sb[$];
  logic [POOL_W-1:0] want_pool = '0;
  logic [ACT_W-1:0] a;
  always #5 clk = ~clk;
  pooling_if pool_bus ();
  pooling_core dut (.clk(clk), .rst(rst), .pool_bus(pool_bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [POOL_W-1:0] ref_pool(input logic [ACT_W-1:0] act, input bit avg);
    logic [POOL_W-1:0] r = '0;
    for (int c = 0; c < NUM_POOLING; c++) begin
      int best = 0, sum = 0;
      for (int k = 0; k < WIN; k++) begin
        int e = int'(act[(c*WIN+k)*B +: B]);
        best = e > best ? e : best;
        sum += e;
      end
      r[c*B +: B] = B'(avg ? sum / WIN : best);
    end
    return r;
  endfunction

  function automatic logic [ACT_W-1:0] fill(input logic [7:0] b);
    return {(ACT_W/8){b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      want_pool = sb[0].val;
      void'(sb.pop_front());
      check("out_valid_hi", 64'(pool_bus.out_valid), 64'd1);
    end else check("out_valid_lo", 64'(pool_bus.out_valid), 64'd0);
    check("pooling_hold", 64'(pool_bus.Pooling), 64'(want_pool));
  endtask

  task automatic drive(input bit r, input bit v, input logic [ACT_W-1:0] act, input bit avg);
    bit m = avg;
`ifndef POOLING_AVG_EN
    m = 1'b0;
`else
    pool_bus.avg_mode = m;
`endif
    rst = r;
    pool_bus.in_valid = v;
    pool_bus.ACTIVATION = act;
    if (r) begin
      sb.delete();
      want_pool = '0;
      last_acc = -1000;
    end else if (v && cyc > last_acc + WIN) begin
      last_acc = cyc;
      sb.push_back('{cyc + WIN + 1, ref_pool(act, m)});
    end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    repeat (5) drive(1'b1, 1'b0, '0, 1'b0);
    idle(100);
    a = fill(8'hFF);
    a[31:0] = 32'hC811_C803;
    drive(1'b0, 1'b1, a, 1'b0);
    idle(4);
    check("max_result", 64'(pool_bus.Pooling), 64'hFFFF_FFFF_FFFF_FFC8);
    idle(3);
    drive(1'b0, 1'b1, fill(8'h10), 1'b0);
    idle(1);
    drive(1'b0, 1'b1, fill(8'hF0), 1'b0);
    idle(2);
    check("busy_ignore", 64'(pool_bus.Pooling), 64'h1010_1010_1010_1010);
    idle(3);
    drive(1'b0, 1'b1, fill(8'h5A), 1'b0);
    idle(4);
    check("b2b_first", 64'(pool_bus.Pooling), 64'h5A5A_5A5A_5A5A_5A5A);
    drive(1'b0, 1'b1, fill(8'h07), 1'b0);
    idle(4);
    check("b2b_second", 64'(pool_bus.Pooling), 64'h0707_0707_0707_0707);
    idle(3);
    drive(1'b0, 1'b1, fill(8'h33), 1'b0);
    idle(2);
    drive(1'b1, 1'b1, fill(8'h99), 1'b0);
    idle(6);
    check("abort_zero", 64'(pool_bus.Pooling), 64'h0);
    drive(1'b0, 1'b1, fill(8'h44), 1'b0);
    idle(4);
    check("after_abort", 64'(pool_bus.Pooling), 64'h4444_4444_4444_4444);
    idle(3);
`ifdef POOLING_AVG_EN
    a = {(ACT_W/32){32'h0403_0201}};
    drive(1'b0, 1'b1, a, 1'b1);
    idle(4);
    check("avg_small", 64'(pool_bus.Pooling), 64'h0202_0202_0202_0202);
    a = {(ACT_W/32){32'hFEFF_FFFF}};
    drive(1'b0, 1'b1, a, 1'b1);
    idle(4);
    check("avg_large", 64'(pool_bus.Pooling), 64'hFEFE_FEFE_FEFE_FEFE);
    idle(3);
`endif
    for (int i = 0; i < 400; i++) begin
      bit r = ($urandom % 50) == 0;
      bit v = ($urandom % 3) != 0;
      bit m = 1'b0;
`ifdef POOLING_AVG_EN
      m = 1'($urandom % 2);
`endif
      for (int w = 0; w < ACT_W/32; w++) a[w*32 +: 32] = $urandom & (($urandom % 2) ? 32'hFFFF_FFFF : 32'h1F1F_1F1F);
      drive(r, v, a, m);
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pooling_core.md
POOLING_CORE -- requirements
Module: pooling_core

Interface
REQ-001 Parameters (name, default, meaning): BOTTLENECK 32, bottleneck depth; SIZE 2, window edge; STRIDE 2, window stride; DELTA_X 4, column step; OU 4, operation-unit rows; IN_CH 512, input channels; IFM_BIT 8, unsigned activation width.
REQ-002 Derived: NUM_CYCLE = BOTTLENECK/DELTA_X*OU*STRIDE (64); NUM_POOLING = IN_CH/NUM_CYCLE (8); WIN = SIZE*SIZE (4).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  ACTIVATION valid this cycle.
REQ-006 ACTIVATION  input  NUM_POOLING*WIN*IFM_BIT  channel c, window element k at bits [(c*WIN+k)*IFM_BIT +: IFM_BIT].
REQ-007 out_valid  output  1  one-cycle result strobe.
REQ-008 Pooling  output  NUM_POOLING*IFM_BIT  channel c result at [c*IFM_BIT +: IFM_BIT].

Function
REQ-009 FSM states IDLE, SCAN, DONE; IDLE->SCAN on in_valid; SCAN->DONE when element counter reaches WIN-1; DONE->SCAN if in_valid, else DONE->IDLE.
REQ-010 On acceptance: capture ACTIVATION into an internal register, clear the element counter, initialise per-channel accumulators to 0.
REQ-011 SCAN: one window element per cycle per channel, all NUM_POOLING channels in parallel, element k on the k-th SCAN cycle.
REQ-012 Max mode: acc = max(acc, elem), unsigned compare; ties keep the equal value.
REQ-013 Latency fixed: in_valid high in cycle n -> out_valid high in cycle n+WIN+1 (n+5 at defaults), for exactly one cycle.
REQ-014 Pooling updates only on the DONE entry edge and holds its value until the next result.
REQ-015 in_valid during SCAN: ignored, data discarded, in-progress result unaffected.
REQ-016 in_valid during DONE: accepted (back-to-back); out_valid still pulses for the current result.
REQ-017 No backpressure; the consumer must sample Pooling while out_valid is high.

Reset
REQ-018 rst high: state IDLE, counter 0, out_valid 0, Pooling 0, captured data 0.
REQ-019 rst has priority over in_valid in the same cycle.
REQ-020 rst mid-SCAN aborts the operation; no out_valid for the aborted input.

Configuration
REQ-021 Macro POOLING_AVG_EN defined: an extra input avg_mode (1 bit) is sampled with in_valid.
REQ-022 When avg_mode is 1, accumulators sum at width IFM_BIT+$clog2(WIN+1); the result is floor(sum/WIN), truncated to IFM_BIT; latency is unchanged.
REQ-023 Macro undefined: no avg_mode port and no adders; max pooling only.

Structure
REQ-024 Shared package pooling_pkg holds NUM_CYCLE, NUM_POOLING, WIN, the FSM state enum and the lane/bus width localparams.
REQ-025 Sub-module pool_lane holds one channel's accumulator and compare/add logic; it is instantiated NUM_POOLING times under a generate loop. The FSM and counter live in pooling_core.

Verification
REQ-026 Reset: rst high 5 cycles, then released with in_valid=0 -> out_valid=0, Pooling=64'h0, no pulse for 100 cycles.
REQ-027 Max: ch0 = {3,200,17,200}, ch1..7 = all 8'hFF, in_valid in cycle n -> out_valid only in cycle n+5, Pooling = 64'hFFFF_FFFF_FFFF_FFC8.
REQ-028 Ignore-while-busy: accept all-8'h10; in cycle n+2 drive in_valid with all-8'hF0 -> one out_valid at n+5, Pooling = 64'h1010_1010_1010_1010, then IDLE.
REQ-029 Back-to-back: second in_valid (all 8'h07) in cycle n+5 -> out_valid at n+5 (first result) and at n+10 = 64'h0707_0707_0707_0707.
REQ-030 Abort: rst high in cycle n+3 for one cycle -> no out_valid; Pooling = 0; a following input completes normally.
REQ-031 POOLING_AVG_EN, avg_mode=1, every channel {1,2,3,4} -> Pooling = 64'h0202_0202_0202_0202 at n+5; {255,255,255,254} -> 8'hFE per channel.
